// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: access sizes,
// bus types, controller states and small decode helpers.
package mem_ctrl_pkg;

   typedef logic [1:0] mem_sel_t;

   localparam mem_sel_t MEM_NOP  = 2'b00;
   localparam mem_sel_t MEM_BYTE = 2'b01;
   localparam mem_sel_t MEM_HALF = 2'b10;
   localparam mem_sel_t MEM_WORD = 2'b11;

   typedef logic [31:0] mem_addr_bus_t;
   typedef logic [7:0]  mem_data_bus_t;

   localparam logic [31:0]   ZERO_WORD = 32'h0;
   localparam mem_data_bus_t ZERO_BYTE = 8'h0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_IF_RD  = 2'b01,
      ST_MEM_RD = 2'b10,
      ST_MEM_WR = 2'b11
   } state_t;

   // Byte count of a transaction; needs to hold 0..4.
   typedef logic [2:0] len_t;

   localparam len_t IF_LEN = 3'd4;

   function automatic len_t sel_len(input mem_sel_t sel);
      case (sel)
         MEM_BYTE: return 3'd1;
         MEM_HALF: return 3'd2;
         MEM_WORD: return 3'd4;
         default:  return 3'd0;
      endcase
   endfunction

   function automatic mem_data_bus_t word_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_ctrl_seq.sv
// Byte sequencer: counts cycles spent in a transaction and flags the last
// issue cycle (cnt == len-1) and the trailing capture cycle (cnt == len).
module mem_ctrl_seq
   import mem_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic step,
   input  logic clear,
   input  len_t len,
   output len_t cnt,
   output logic last_byte,
   output logic last_cycle
);

   len_t len_q;

   // NOTE: state registers take non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         len_q <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (start) begin
         cnt   <= '0;
         len_q <= len;
      end else if (step) begin
         cnt <= cnt + 3'd1;
      end
   end

   assign last_byte  = (cnt == len_q - 3'd1);
   assign last_cycle = (cnt == len_q);

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller: arbitrates MEM-stage loads/stores against
// instruction fetches and sequences each into per-byte RAM cycles.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  mem_sel_t          mem_sel_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output mem_data_bus_t     ram_dout_o,
   input  mem_data_bus_t     ram_din_i
);

   state_t            state;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0]       wdata_q;
   logic [31:0]       rd_buf;
   logic [31:0]       rd_merged;
   logic [ADDR_W-1:0] next_addr;
   logic [1:0]        cap_idx;
   logic [1:0]        wr_idx;
   logic              mem_go;
   logic              if_go;
   logic              busy_end;
   logic              seq_step;
   len_t              seq_len;
   len_t              cnt;
   logic              last_byte;
   logic              last_cycle;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      mem_go    = 1'b0;
      if_go     = 1'b0;
      busy_end  = 1'b0;
      seq_len   = IF_LEN;
      rd_merged = rd_buf;
      cap_idx   = 2'(cnt - 3'd1);
      wr_idx    = 2'(cnt + 3'd1);
      next_addr = base_addr + ADDR_W'(cnt) + ADDR_W'(1);

      // A port whose done pulse is showing has not yet dropped its request.
      if (state == ST_IDLE) begin
         mem_go = mem_req_i && (mem_sel_i != MEM_NOP) && !mem_done_o;
         if_go  = !mem_go && if_req_i && !if_flush_i && !if_done_o;
      end
      if (mem_go) seq_len = sel_len(mem_sel_i);

      case (state)
         ST_MEM_WR: busy_end = last_byte;
         ST_MEM_RD: busy_end = last_cycle;
         ST_IF_RD:  busy_end = last_cycle || if_flush_i;
         default:   busy_end = 1'b0;
      endcase

      // The byte issued last cycle is on ram_din_i now.
      if (cnt != 3'd0) rd_merged[{cap_idx, 3'b000} +: 8] = ram_din_i;
   end

   assign seq_step = (state != ST_IDLE) && !busy_end;

   mem_ctrl_seq u_seq (
      .clk        (clk),
      .rst        (rst),
      .start      (mem_go || if_go),
      .step       (seq_step),
      .clear      (busy_end),
      .len        (seq_len),
      .cnt        (cnt),
      .last_byte  (last_byte),
      .last_cycle (last_cycle)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         base_addr   <= '0;
         wdata_q     <= ZERO_WORD;
         rd_buf      <= ZERO_WORD;
         ram_addr_o  <= IDLE_ADDR;
         ram_we_o    <= 1'b0;
         ram_dout_o  <= ZERO_BYTE;
         if_data_o   <= ZERO_WORD;
         mem_rdata_o <= ZERO_WORD;
         if_done_o   <= 1'b0;
         mem_done_o  <= 1'b0;
      end else begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               ram_we_o   <= 1'b0;
               ram_dout_o <= ZERO_BYTE;
               ram_addr_o <= IDLE_ADDR;
               if (mem_go) begin
                  base_addr  <= mem_addr_i;
                  wdata_q    <= mem_wdata_i;
                  rd_buf     <= ZERO_WORD;
                  ram_addr_o <= mem_addr_i;
                  if (mem_we_i) begin
                     state      <= ST_MEM_WR;
                     ram_we_o   <= 1'b1;
                     ram_dout_o <= word_byte(mem_wdata_i, 2'd0);
                  end else begin
                     state <= ST_MEM_RD;
                  end
               end else if (if_go) begin
                  base_addr  <= if_addr_i;
                  rd_buf     <= ZERO_WORD;
                  ram_addr_o <= if_addr_i;
                  state      <= ST_IF_RD;
               end
            end

            ST_MEM_WR: begin
               if (last_byte) begin
                  state      <= ST_IDLE;
                  ram_we_o   <= 1'b0;
                  ram_dout_o <= ZERO_BYTE;
                  ram_addr_o <= IDLE_ADDR;
                  mem_done_o <= 1'b1;
               end else begin
                  ram_addr_o <= next_addr;
                  ram_dout_o <= word_byte(wdata_q, wr_idx);
               end
            end

            ST_IF_RD, ST_MEM_RD: begin
               rd_buf <= rd_merged;
               if (state == ST_IF_RD && if_flush_i) begin
                  state      <= ST_IDLE;
                  ram_addr_o <= IDLE_ADDR;
               end else if (last_cycle) begin
                  state      <= ST_IDLE;
                  ram_addr_o <= IDLE_ADDR;
                  if (state == ST_IF_RD) begin
                     if_data_o <= rd_merged;
                     if_done_o <= 1'b1;
                  end else begin
                     mem_rdata_o <= rd_merged;
                     mem_done_o  <= 1'b1;
                  end
               end else if (last_byte) begin
                  ram_addr_o <= IDLE_ADDR;
               end else begin
                  ram_addr_o <= next_addr;
               end
            end

            default: begin
               state      <= ST_IDLE;
               ram_we_o   <= 1'b0;
               ram_addr_o <= IDLE_ADDR;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the pipeline and the single 8-bit RAM/IO port.
- Arbitrates instruction-fetch word reads (IF) and load/store requests from the MEM stage.
- Sequences them into per-byte RAM cycles and returns assembled little-endian data with a one-cycle done pulse.
- Sits directly downstream of the MEM and IF stages; owns the RAM port exclusively.

Parameters:
- ADDR_W, 32, width of all byte addresses.
- IDLE_ADDR, 32'h0, value driven on ram_addr_o when no transaction is active; keeps the HCI/IO decoder quiet.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- if_req_i  in  1  level request: fetch 4 bytes at if_addr_i
- if_addr_i  in  32  fetch byte address
- if_flush_i  in  1  abort in-flight or pending fetch (branch redirect)
- if_data_o  out  32  fetched word {b3,b2,b1,b0}
- if_done_o  out  1  one-cycle pulse: if_data_o valid
- mem_req_i  in  1  level request from MEM stage
- mem_we_i  in  1  1=store, 0=load
- mem_sel_i  in  2  MEM_NOP/MEM_BYTE/MEM_HALF/MEM_WORD
- mem_addr_i  in  32  first byte address
- mem_wdata_i  in  32  store data, byte k = bits [8k+7:8k]
- mem_rdata_o  out  32  load data, zero-extended; sign extension is done in MEM
- mem_done_o  out  1  one-cycle pulse: load data valid / store committed
- ram_addr_o  out  32  RAM byte address
- ram_we_o  out  1  RAM write enable
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. On reset:
  - state=IDLE; byte counter=0.
  - ram_addr_o=IDLE_ADDR, ram_we_o=0, ram_dout_o=0.
  - if_data_o=0, mem_rdata_o=0, if_done_o=0, mem_done_o=0.
  - Reset mid-transaction abandons it with no done pulse.
- All outputs are registered.
- RAM timing: the address presented in cycle t returns ram_din_i valid in cycle t+1; the controller samples it at the end of t+1.
- Writes take effect in the cycle ram_we_o=1.
- Length N from sel: BYTE=1, HALF=2, WORD=4, IF=4. MEM_NOP with mem_req_i is ignored and stays IDLE.
- States:
  - IDLE
    - mem_req_i (sel≠NOP) has priority over if_req_i; MEM holds the older instruction.
    - Latch the request and go to MEM_RD, MEM_WR or IF_RD.
    - A port whose done pulse is high in this cycle is ignored for that cycle (prevents double issue).
  - MEM_WR, cycles k=0..N-1
    - ram_addr_o=addr+k, ram_dout_o=wdata byte k, ram_we_o=1.
    - After byte N-1: go to IDLE, ram_we_o=0, ram_addr_o=IDLE_ADDR, mem_done_o=1 for one cycle.
    - Store latency: N+1 cycles from the IDLE cycle in which the request is accepted to the done pulse.
  - MEM_RD / IF_RD, issue cycles k=0..N-1, capture cycles k=1..N
    - Capture byte k-1 into data[8(k-1)+7:8(k-1)]; issue and capture overlap.
    - After final capture: done=1 for one cycle, data output valid in the same cycle, ram_addr_o=IDLE_ADDR.
    - Read latency: N+2 cycles from acceptance to the done pulse.
    - Unused upper bytes of mem_rdata_o are 0.
- Addresses are latched at acceptance. addr+k wraps modulo 2^32. No alignment requirement.
- Requesters hold req/addr/data stable until done. Input changes mid-transaction are ignored because operands are latched.
- if_flush_i:
  - In IF_RD: abort at the next edge, go to IDLE, no if_done_o, ram_addr_o=IDLE_ADDR.
  - In IDLE: suppresses acceptance of if_req_i that cycle.
  - No effect on MEM_RD/MEM_WR; memory transactions are never aborted.
- Simultaneous if_done_o and mem_done_o is impossible; at most one done is high per cycle.
- ram_we_o is never 1 outside MEM_WR.

Decomposition:
- Shared defines header:
  - MEM_NOP=2'b00, MEM_BYTE=2'b01, MEM_HALF=2'b10, MEM_WORD=2'b11
  - MemAddrBus [31:0], MemDataBus [7:0], ZeroWord, ZeroByte
  - state encodings for IDLE/IF_RD/MEM_RD/MEM_WR
- No sub-module needed. Optional: mem_byte_seq (counter + length decode + done generation), instantiated once.

Test Plan:
- IF fetch: if_req_i=1, addr=0x100, RAM bytes 0x13,0x05,0x50,0x00 at 0x100..0x103 → ram_addr_o 0x100..0x103 over 4 cycles; if_done_o pulses at cycle 6 with if_data_o=0x00500513; ram_addr_o returns to 0.
- Store word: mem_we_i=1, sel=WORD, addr=0x1000, wdata=0xDEADBEEF → ram_we_o high 4 cycles writing EF,BE,AD,DE to 0x1000..0x1003; mem_done_o pulses once; ram_we_o=0 afterward.
- Load byte / half: sel=BYTE at 0x2003 holding 0x80 → mem_rdata_o=0x00000080 at latency 3. sel=HALF at 0xFFFFFFFF → addresses 0xFFFFFFFF then 0x00000000 (wrap).
- Arbitration: if_req_i and mem_req_i raised in the same cycle → MEM served first. IF starts in the cycle after mem_done_o and completes correctly; no overlapping RAM accesses.
- Flush: if_flush_i asserted at IF_RD byte 2 → no if_done_o, state IDLE next cycle. A following MEM load completes normally. Flush during MEM_WR → store completes all bytes.
- Reset mid-store: rst after byte 1 of a word store → ram_we_o=0, ram_addr_o=0, no mem_done_o; a new request after reset is accepted normally.
